// File: rtl/dbus_responder_if.sv
// -----------------------------------------------------------------------------
// dbus_if : data-bus connection between the core (master) and the memory-side
//           responder (slave).
//
//   dreq  : core request    - valid, addr[63:0], size, strobe[7:0], data[63:0]
//   dresp : responder reply - addr_ok, data_ok, data[63:0]
//
//   modport master : drives dreq, observes dresp   (core side)
//   modport slave  : observes dreq, drives dresp   (memory side)
// -----------------------------------------------------------------------------
interface dbus_if;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input  dresp);
    modport slave  (input  dreq, output dresp);

endinterface

// File: rtl/dbus_responder.sv
// -----------------------------------------------------------------------------
// dbus_responder : fixed-latency 64-bit RAM standing in for the memory system
//                  at the far end of the core's data bus.
//
// Parameters
//   MEM_WORDS : RAM depth in 64-bit words (power of two)
//   LATENCY   : wait cycles between request capture and completion (0..15)
//   BASE_ADDR : byte address of word 0 (8-byte aligned)
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-low reset
//   bus       slave side of dbus_if (dreq in, dresp out)
//   oob       out  one-cycle pulse alongside a completion outside the RAM window
//   txn_count out  completed transactions, wraps modulo 2^32
//
// A request is captured once in IDLE; the core holds it stable until data_ok.
// Dropping valid while waiting aborts the request without side effects.
// -----------------------------------------------------------------------------
module dbus_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    dbus_if.slave       bus,
    output logic        oob,
    output logic [31:0] txn_count
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [63:0] WIN_BYTES = 64'(MEM_WORDS) * 64'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_n_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_n_s;
    logic               capture_s;

    logic [63:0]        addr_r;
    logic [7:0]         strobe_r;
    logic [63:0]        data_r;

    logic               resp_r;
    logic               oob_r;
    logic [63:0]        rdata_r;
    logic [31:0]        txn_r;

    logic [63:0]        look_addr_s;
    logic [63:0]        offset_s;
    logic               in_range_s;
    logic [IDX_W-1:0]   idx_s;
    logic               unused_s;

    logic [63:0]        mem_r [MEM_WORDS];

    // Byte-lane merge: lanes with a strobe bit take the new data, others keep the old word.
    function automatic logic [63:0] merge_bytes(input logic [63:0] old_word,
                                                input logic [63:0] new_word,
                                                input logic [7:0]  strobe);
        logic [63:0] res;
        res = old_word;
        for (int i = 0; i < 8; i++) begin
            if (strobe[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Next-state and wait-counter logic.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.dreq.valid) begin
                    capture_s = 1'b1;
                    cnt_n_s   = 4'(LATENCY);
                    state_n_s = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.dreq.valid) begin
                    state_n_s = ST_IDLE;
                end else begin
                    cnt_n_s = cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_n_s = ST_RESP;
                    end else begin
                        state_n_s = ST_WAIT;
                    end
                end
            end
            ST_RESP: begin
                // valid still high here belongs to the completing request
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Address decode. With LATENCY 0 the read happens on the capture edge,
    // so the live request address is used then; otherwise the captured one.
    always_comb begin
        look_addr_s = capture_s ? bus.dreq.addr : addr_r;
        // Unsigned wrap makes addresses below BASE_ADDR land far above the window.
        offset_s    = look_addr_s - BASE_ADDR;
        in_range_s  = (offset_s < WIN_BYTES);
        idx_s       = offset_s[IDX_W+2:3];
    end

    // size is informational only; strobe alone selects bytes.
    assign unused_s = ^bus.dreq.size;

    // Control state, request capture, response registers and transaction counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            addr_r   <= 64'd0;
            strobe_r <= 8'd0;
            data_r   <= 64'd0;
            resp_r   <= 1'b0;
            oob_r    <= 1'b0;
            rdata_r  <= 64'd0;
            txn_r    <= 32'd0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            if (capture_s) begin
                addr_r   <= bus.dreq.addr;
                strobe_r <= bus.dreq.strobe;
                data_r   <= bus.dreq.data;
            end
            resp_r <= (state_n_s == ST_RESP);
            oob_r  <= (state_n_s == ST_RESP) && !in_range_s;
            if (state_n_s == ST_RESP) begin
                rdata_r <= in_range_s ? mem_r[idx_s] : 64'd0;
            end
            if (state_r == ST_RESP) begin
                txn_r <= txn_r + 32'd1;
            end
        end
    end

    // RAM write on the edge ending RESP; reset at that edge cancels it.
    always_ff @(posedge clk) begin
        if (reset && (state_r == ST_RESP) && in_range_s && (strobe_r != 8'd0)) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], data_r, strobe_r);
        end
    end

    assign bus.dresp = '{addr_ok: resp_r, data_ok: resp_r, data: rdata_r};
    assign oob       = oob_r;
    assign txn_count = txn_r;

endmodule

// File: doc/dbus_responder.md
# dbus_responder

Memory-side responder for the core's data bus: accepts `dbus_req_t` requests from the core, models a fixed-latency 64-bit RAM, and returns `dbus_resp_t` completions. It is the far end of the core's data-bus interface in the simulation top, standing in for the memory system. It also flags out-of-range accesses and counts completed transactions for bring-up debug.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 64-bit words; must be a power of two.
- `LATENCY`, 2: wait cycles between request capture and completion; range 0–15.
- `BASE_ADDR`, 64'h8000_0000: byte address of word 0; must be 8-byte aligned.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset), sampled on `clk` rising edge.
- `dreq`  in  `dbus_req_t`  core request: `valid`, `addr[63:0]`, `size`, `strobe[7:0]`, `data[63:0]`.
- `dresp`  out  `dbus_resp_t`  response: `addr_ok`, `data_ok`, `data[63:0]`.
- `oob`  out  1  one-cycle pulse with a completion whose address was outside the RAM window.
- `txn_count`  out  32  number of completed transactions; wraps modulo 2^32.

## Operation
- Window: `addr` in [BASE_ADDR, BASE_ADDR + 8*MEM_WORDS). Word index = (addr − BASE_ADDR) >> 3; `addr[2:0]` ignored. `size` ignored; `strobe` alone selects bytes.
- Read = `strobe` == 0; write = any strobe bit set.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if `dreq.valid`, capture addr/strobe/data, load `cnt` = LATENCY; go to RESP if LATENCY == 0, else WAIT.
  - WAIT: if `dreq.valid` == 0, abort → IDLE (no write, no response). Else decrement `cnt`; when `cnt` reaches 1 at this edge → RESP.
  - RESP: `addr_ok` = `data_ok` = 1 for exactly this cycle; → IDLE.
- Read data: full 64-bit word at the captured index, unshifted (core performs byte extraction). Read performed at entry to RESP; `dresp.data` registered and held until next RESP.
- Write: at the edge ending RESP, byte i of the word is replaced by `data[8i+7:8i]` where `strobe[i]`=1; other bytes untouched.
- Out-of-range: read returns 64'h0, write dropped; completion still delivered; `oob` = 1 in the RESP cycle.
- `txn_count` increments at the edge ending each RESP cycle; aborted requests not counted.
- Core must hold `dreq` stable from first valid cycle through the `data_ok` cycle; fields are captured once, later changes ignored.

## Timing
- Reset: state IDLE; `addr_ok`, `data_ok`, `oob` = 0; `dresp.data` = 0; `txn_count` = 0. RAM contents not cleared.
- Reset asserted mid-transaction: abort at that edge; no write, no response, state IDLE.
- Latency: `dreq.valid` first high in cycle t (in IDLE) → `data_ok` high in cycle t+LATENCY+1.
- All outputs registered; no combinational path from `dreq` to `dresp`.
- Back-to-back: IDLE after RESP accepts in its first cycle; with `valid` held continuously, completions every LATENCY+2 cycles. `valid` high during the RESP cycle does not start a new transaction (the core is presenting the completing request).
- Read-after-write to same word in consecutive transactions returns the written data.

## Test plan
- LATENCY=2: write addr 0x8000_0010, strobe 0xFF, data 0x1122_3344_5566_7788 (valid at t) → `data_ok` at t+3, `txn_count`=1; read same addr → data 0x1122_3344_5566_7788, `txn_count`=2.
- Partial write strobe 0x0F data 0xAAAA_AAAA_BBBB_BBBB over word 0x1122_3344_5566_7788 → readback 0x1122_3344_BBBB_BBBB.
- Read addr 0x7FFF_FFF8 and write addr BASE_ADDR+8*MEM_WORDS → each completes with `oob`=1, read data 0, no RAM word modified.
- LATENCY=0: read with `valid` held → `data_ok` in cycle t+1; `valid` held continuously → `data_ok` every 2 cycles.
- Drop `valid` during WAIT of a write → no `data_ok`, `txn_count` unchanged, word unchanged; next request completes normally.
- Assert `reset`=0 during WAIT of a write → outputs 0, `txn_count`=0, word unchanged; after release a read returns pre-write contents.
